// File: rtl/cdma_stripe_mux.sv
// rtl/cdma_stripe_mux.sv - merges striped per-channel data streams into one stream per mux command
//
// Consumes (vfid, len, ctl) commands and forwards len+1 beats taken round-robin
// across the channel streams, starting at channel vfid. tlast marks the final
// beat of each command; s_mux_done pulses once per completed command with ctl set.
//
// Ports:
//   aclk, aresetn                  clock, asynchronous active-low reset
//   s_mux_valid/ready              command handshake
//   s_mux_vfid/len/ctl             start channel, beats-1, done request
//   s_mux_done                     one-cycle completion pulse
//   s_axis_tvalid/tready           per-channel stream handshake (N_CH wide)
//   s_axis_tdata/tkeep/tlast       per-channel payload, channel i at slice i (tlast unused)
//   m_axis_tvalid/tready           merged stream handshake
//   m_axis_tdata/tkeep/tlast       merged payload, tlast generated from the command length
module cdma_stripe_mux #(
    parameter int N_CH      = 4,
    parameter int DATA_BITS = 64,
    parameter int BLEN_BITS = 8,
    parameter int ID_BITS   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       s_mux_valid,
    output logic                       s_mux_ready,
    input  logic [ID_BITS-1:0]         s_mux_vfid,
    input  logic [BLEN_BITS-1:0]       s_mux_len,
    input  logic                       s_mux_ctl,
    output logic                       s_mux_done,
    input  logic [N_CH-1:0]            s_axis_tvalid,
    output logic [N_CH-1:0]            s_axis_tready,
    input  logic [N_CH*DATA_BITS-1:0]  s_axis_tdata,
    input  logic [N_CH*DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic [N_CH-1:0]            s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [DATA_BITS-1:0]       m_axis_tdata,
    output logic [DATA_BITS/8-1:0]     m_axis_tkeep,
    output logic                       m_axis_tlast
);

    localparam int KEEP_BITS = DATA_BITS / 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ID_BITS-1:0]   ptr_q, ptr_d;
    logic [BLEN_BITS-1:0] cnt_q, cnt_d;
    logic                 ctl_q, ctl_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;

    logic                 in_xfer;
    logic [N_CH-1:0]      sel_onehot;
    logic                 sel_valid;
    logic [DATA_BITS-1:0] sel_data;
    logic [KEEP_BITS-1:0] sel_keep;
    logic                 out_hs;

    // Channel tlast is not meaningful here: beat count comes from the command.
    logic unused_tlast;
    assign unused_tlast = ^s_axis_tlast;

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ctl_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // Channel select: decode ptr once, reuse for data mux and tready steering.
    always_comb begin
        sel_onehot = '0;
        sel_valid  = 1'b0;
        sel_data   = '0;
        sel_keep   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ptr_q == ID_BITS'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_valid     = s_axis_tvalid[i];
                sel_data      = s_axis_tdata[i*DATA_BITS +: DATA_BITS];
                sel_keep      = s_axis_tkeep[i*KEEP_BITS +: KEEP_BITS];
            end
        end
    end

    // Output logic: everything except ready/done is combinational from state.
    always_comb begin
        in_xfer       = (state_q == S_XFER);
        m_axis_tvalid = in_xfer && sel_valid;
        m_axis_tdata  = in_xfer ? sel_data : '0;
        m_axis_tkeep  = in_xfer ? sel_keep : '0;
        m_axis_tlast  = in_xfer && (cnt_q == '0);
        s_axis_tready = (in_xfer && m_axis_tready) ? sel_onehot : '0;
        out_hs        = m_axis_tvalid && m_axis_tready;
        s_mux_ready   = ready_q;
        s_mux_done    = done_q;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ctl_d   = ctl_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        case (state_q)
            S_IDLE: begin
                // ready comes up on the first edge after reset release
                ready_d = 1'b1;
                if (s_mux_valid && ready_q) begin
                    ptr_d   = s_mux_vfid;
                    cnt_d   = s_mux_len;
                    ctl_d   = s_mux_ctl;
                    ready_d = 1'b0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (out_hs) begin
                    // explicit wrap so non-power-of-2 channel counts work
                    ptr_d = (ptr_q == ID_BITS'(N_CH - 1)) ? '0 : ptr_q + ID_BITS'(1);
                    cnt_d = cnt_q - BLEN_BITS'(1);
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = ctl_q;
                        ready_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Upstream must never hand over a start channel beyond the stripe width.
    a_vfid_legal: assert property (@(posedge aclk) disable iff (!aresetn)
        (s_mux_valid && s_mux_ready) |-> (32'(s_mux_vfid) < N_CH));

    a_tready_selected: assert property (@(posedge aclk) disable iff (!aresetn)
        (s_axis_tready & ~sel_onehot) == '0);

    a_no_tvalid_idle: assert property (@(posedge aclk) disable iff (!aresetn)
        (state_q == S_IDLE) |-> !m_axis_tvalid);

endmodule

// File: tb/tb_cdma_stripe_mux.sv
// tb/tb_cdma_stripe_mux.sv - scoreboard bench for cdma_stripe_mux
module tb_cdma_stripe_mux;

    localparam int N_CH = 4;
    localparam int DB   = 32;
    localparam int KB   = DB / 8;
    localparam int BL   = 8;
    localparam int IB   = 2;

    logic               aclk = 1'b0;
    logic               aresetn;
    logic               s_mux_valid;
    logic               s_mux_ready;
    logic [IB-1:0]      s_mux_vfid;
    logic [BL-1:0]      s_mux_len;
    logic               s_mux_ctl;
    logic               s_mux_done;
    logic [N_CH-1:0]    s_axis_tvalid;
    logic [N_CH-1:0]    s_axis_tready;
    logic [N_CH*DB-1:0] s_axis_tdata;
    logic [N_CH*KB-1:0] s_axis_tkeep;
    logic [N_CH-1:0]    s_axis_tlast;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic [DB-1:0]      m_axis_tdata;
    logic [KB-1:0]      m_axis_tkeep;
    logic               m_axis_tlast;

    always #5 aclk = ~aclk;

    cdma_stripe_mux #(.N_CH(N_CH), .DATA_BITS(DB), .BLEN_BITS(BL), .ID_BITS(IB)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_mux_valid(s_mux_valid), .s_mux_ready(s_mux_ready), .s_mux_vfid(s_mux_vfid),
        .s_mux_len(s_mux_len), .s_mux_ctl(s_mux_ctl), .s_mux_done(s_mux_done),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast)
    );

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic [3:0]  keep;
        bit          last;
        bit          ctl;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   sseq[N_CH];
    int   mseq[N_CH];
    bit   consume[N_CH];
    int   vprob = 100;
    int   rprob = 100;
    int   low0 = 0;
    exp_t q[$];
    bit   done_exp = 1'b0;
    int   popped = 0;
    int   last_hs_cyc = 0;
    int   acc_cyc = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] src_data(int ch, int seq);
        return {8'(ch), 24'(seq)};
    endfunction

    function automatic logic [3:0] src_keep(int ch, int seq);
        return 4'(seq) ^ 4'(ch);
    endfunction

    always @(posedge aclk) cyc <= cyc + 1;

    // Channel sources and sink: each channel is an independent numbered stream.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            for (int i = 0; i < N_CH; i++) if (consume[i]) sseq[i]++;
            for (int i = 0; i < N_CH; i++) s_axis_tvalid[i] = ($urandom_range(99) < vprob);
            if (low0 > 0) begin
                s_axis_tvalid[0] = 1'b0;
                low0--;
            end
            for (int i = 0; i < N_CH; i++) begin
                s_axis_tdata[i*DB +: DB] = src_data(i, sseq[i]);
                s_axis_tkeep[i*KB +: KB] = src_keep(i, sseq[i]);
            end
            s_axis_tlast  = 4'($urandom);
            m_axis_tready = ($urandom_range(99) < rprob);
        end
    end

    // Monitor: compares every cycle against the head of the expected queue.
    always @(negedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < N_CH; i++) consume[i] = 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) consume[i] = s_axis_tready[i] && s_axis_tvalid[i];
            chk("s_mux_done", s_mux_done, done_exp);
            done_exp = 1'b0;
            if (q.size() == 0) begin
                chk("idle_m_tvalid", m_axis_tvalid, 0);
                chk("idle_s_tready", s_axis_tready, 0);
            end else begin
                exp_t h;
                h = q[0];
                chk("m_tvalid_follows_sel", m_axis_tvalid, s_axis_tvalid[h.ch]);
                chk("s_tready_sel", s_axis_tready, m_axis_tready ? (4'b0001 << h.ch) : 4'b0000);
                if (m_axis_tvalid && m_axis_tready) begin
                    chk("m_tdata", m_axis_tdata, h.data);
                    chk("m_tkeep", m_axis_tkeep, h.keep);
                    chk("m_tlast", m_axis_tlast, h.last);
                    if (h.last) begin
                        done_exp    = h.ctl;
                        last_hs_cyc = cyc;
                    end
                    popped++;
                    void'(q.pop_front());
                end
            end
        end
    end

    // Reference: command expands into len+1 beats over channels (vfid+k) mod N_CH.
    task automatic model_cmd(int vf, int ln, bit ct);
        for (int k = 0; k <= ln; k++) begin
            exp_t e;
            e.ch   = (vf + k) % N_CH;
            e.data = src_data(e.ch, mseq[e.ch]);
            e.keep = src_keep(e.ch, mseq[e.ch]);
            e.last = (k == ln);
            e.ctl  = ct;
            mseq[e.ch]++;
            q.push_back(e);
        end
    endtask

    task automatic issue(int vf, int ln, bit ct);
        int n = 0;
        @(posedge aclk);
        #1;
        s_mux_valid = 1'b1;
        s_mux_vfid  = IB'(vf);
        s_mux_len   = BL'(ln);
        s_mux_ctl   = ct;
        forever begin
            @(negedge aclk);
            if (s_mux_ready) break;
            n++;
            if (n > 2000) begin
                timeout("cmd_accept");
                s_mux_valid = 1'b0;
                return;
            end
        end
        acc_cyc = cyc;
        @(posedge aclk);
        model_cmd(vf, ln, ct);
        #1;
        s_mux_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || done_exp) && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 3000) timeout("drain");
    endtask

    task automatic reset_check(string tag);
        chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_s_tready"}, s_axis_tready, 0);
        chk({tag, "_m_tlast"}, m_axis_tlast, 0);
        chk({tag, "_mux_ready"}, s_mux_ready, 0);
        chk({tag, "_mux_done"}, s_mux_done, 0);
    endtask

    // Abandon the in-flight command: un-issued beats return to their channels.
    task automatic abort_reset();
        aresetn = 1'b0;
        #1;
        reset_check("abort");
        foreach (q[i]) mseq[q[i].ch]--;
        q.delete();
        done_exp = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("ready_after_abort", s_mux_ready, 1);
    endtask

    initial begin
        int base;
        int n;
        aresetn       = 1'b0;
        s_mux_valid   = 1'b0;
        s_mux_vfid    = '0;
        s_mux_len     = '0;
        s_mux_ctl     = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #2;
        reset_check("reset");
        @(negedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("ready_after_reset", s_mux_ready, 1);

        // T1 / T2: full-rate transfer starting mid-stripe, with and without done
        issue(2, 5, 1'b1);
        wait_idle();
        issue(2, 5, 1'b0);
        wait_idle();

        // T3: single beat, ready returns after the one beat completes
        issue(3, 0, 1'b1);
        @(negedge aclk);
        chk("t3_ready_busy", s_mux_ready, 0);
        @(negedge aclk);
        chk("t3_ready_back", s_mux_ready, 1);
        wait_idle();

        // T4: sink backpressure and channel 0 starved for 4 cycles
        rprob = 50;
        issue(2, 5, 1'b1);
        low0 = 4;
        wait_idle();

        // T5: back-to-back commands with a single idle cycle between them
        rprob = 100;
        issue(1, 2, 1'b1);
        issue(0, 3, 1'b1);
        chk("t5_gap", 32'(acc_cyc - last_hs_cyc), 1);
        wait_idle();

        // T6: reset after 2 of 6 beats, then a fresh command
        issue(1, 5, 1'b1);
        base = popped;
        n = 0;
        while (popped < base + 2 && n < 100) begin
            @(posedge aclk);
            n++;
        end
        if (n >= 100) timeout("t6_beats");
        #2;
        abort_reset();
        issue(3, 2, 1'b1);
        wait_idle();

        // Random commands under random source/sink stalls
        vprob = 80;
        rprob = 50;
        repeat (40) begin
            issue($urandom_range(N_CH - 1), $urandom_range(7), 1'($urandom));
            if ($urandom_range(3) == 0) wait_idle();
        end
        wait_idle();
        repeat (3) @(negedge aclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
